// File: rtl/osd_mam_wb_burst_if_if.sv
// ---------------------------------------------------------------------------
// osd_mam_wb_burst_if_if
// Wishbone B3 bus bundle used by the MAM burst back end.
//   master modport : cyc/stb/we/addr/dat_o/sel/cti/bte out, ack/err/dat_i in
//   slave  modport : the mirror image, for the interconnect or a bus model
// ---------------------------------------------------------------------------
interface osd_mam_wb_burst_if_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int SW = DATA_WIDTH / 8;

    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [SW-1:0]         sel_o;
    logic [2:0]            cti_o;
    logic [1:0]            bte_o;
    logic                  ack_i;
    logic                  err_i;
    logic [DATA_WIDTH-1:0] dat_i;

    modport master (
        output cyc_o, stb_o, we_o, addr_o, dat_o, sel_o, cti_o, bte_o,
        input  ack_i, err_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, addr_o, dat_o, sel_o, cti_o, bte_o,
        output ack_i, err_i, dat_i
    );
endinterface

// File: rtl/osd_mam_wb_burst_if.sv
// ---------------------------------------------------------------------------
// osd_mam_wb_burst_if
// MAM request -> Wishbone B3 classic / incrementing-burst master.
//   clk_i, rst_i              : clock, async active-high reset
//   req_*                     : request handshake (rw, start addr, burst, beats)
//   write_valid/ready/data/strb : write data stream (strb only for single writes)
//   read_valid/ready/data     : read data stream, fed from a small FIFO
//   err_o                     : sticky bus error, cleared on next accepted request
//   wb                        : Wishbone master port
// ---------------------------------------------------------------------------
module osd_mam_wb_burst_if #(
    parameter int  DATA_WIDTH    = 32,
    parameter int  ADDR_WIDTH    = 32,
    parameter int  RD_FIFO_DEPTH = 4,
    localparam int SW            = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_burst,
    input  logic [13:0]           req_beats,

    input  logic                  write_valid,
    output logic                  write_ready,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [SW-1:0]         write_strb,

    output logic                  read_valid,
    input  logic                  read_ready,
    output logic [DATA_WIDTH-1:0] read_data,

    output logic                  err_o,

    osd_mam_wb_burst_if_if.master wb
);
    localparam int PW = $clog2(RD_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, READ_DRAIN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [SW-1:0]         sel_q;
    logic                  burst_q;
    logic [13:0]           cnt_q;

    logic [DATA_WIDTH-1:0] fifo_mem [RD_FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW:0]           fill_q;

    logic        beat;
    logic        last_beat;
    logic        push;
    logic        pop;
    logic        in_xfer;
    logic [13:0] n_beats;

    // A zero beat count or a non-burst request is always a single beat.
    assign n_beats   = (req_burst && req_beats != 14'd0) ? req_beats : 14'd1;

    assign in_xfer   = (state_q == WRITE) || (state_q == READ);
    assign last_beat = (cnt_q == 14'd1);
    assign beat      = wb.stb_o & (wb.ack_i | wb.err_i);
    assign push      = (state_q == READ) & beat;
    assign pop       = read_valid & read_ready;

    assign req_ready   = (state_q == IDLE);
    assign write_ready = (state_q == WRITE) & beat;
    assign read_valid  = (fill_q != '0);
    assign read_data   = fifo_mem[rd_ptr_q];

    assign wb.cyc_o  = in_xfer;
    assign wb.we_o   = we_q;
    assign wb.addr_o = addr_q;
    assign wb.sel_o  = sel_q;
    assign wb.dat_o  = write_data;
    assign wb.bte_o  = 2'b00;

    // Reads back off with cyc held when the FIFO cannot take another word,
    // so a slow consumer never loses data.
    always_comb begin
        wb.stb_o = 1'b0;
        case (state_q)
            WRITE:   wb.stb_o = write_valid;
            READ:    wb.stb_o = (fill_q != (PW+1)'(RD_FIFO_DEPTH));
            default: wb.stb_o = 1'b0;
        endcase
    end

    // Burst requests always signal end-of-burst on the final beat, even N=1.
    always_comb begin
        wb.cti_o = 3'b000;
        if (in_xfer && burst_q)
            wb.cti_o = last_beat ? 3'b111 : 3'b010;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            burst_q <= 1'b0;
            cnt_q   <= '0;
            err_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_rw;
                        burst_q <= req_burst;
                        cnt_q   <= n_beats;
                        sel_q   <= (req_rw && !req_burst) ? write_strb : '1;
                        err_o   <= 1'b0;
                        state_q <= req_rw ? WRITE : READ;
                    end
                end
                WRITE, READ: begin
                    if (beat) begin
                        // Errors still count as a beat so the MAM sees the
                        // full word count.
                        if (wb.err_i)
                            err_o <= 1'b1;
                        addr_q <= addr_q + ADDR_WIDTH'(SW);
                        cnt_q  <= cnt_q - 14'd1;
                        if (last_beat)
                            state_q <= (state_q == WRITE) ? IDLE : READ_DRAIN;
                    end
                end
                READ_DRAIN: begin
                    if (fill_q == '0 || (fill_q == (PW+1)'(1) && pop))
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read FIFO bookkeeping; pointers wrap naturally as depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + (PW+1)'(1);
                2'b01:   fill_q <= fill_q - (PW+1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            fifo_mem[wr_ptr_q] <= wb.dat_i;
    end
endmodule

// File: tb/tb_osd_mam_wb_burst_if.sv
// ---------------------------------------------------------------------------
// tb_osd_mam_wb_burst_if
// Randomised bench for osd_mam_wb_burst_if. A behavioural Wishbone slave
// answers bus cycles; each test derives expected beats (address, cti, sel,
// data) and read-word order from the request rules with plain arithmetic.
// A second instance with an 8-bit address bus covers address wrap.
// ---------------------------------------------------------------------------
module tb_osd_mam_wb_burst_if;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---- main instance (32-bit address) ----
    logic        req_valid = 1'b0, req_ready, req_rw = 1'b0, req_burst = 1'b0;
    logic [31:0] req_addr = '0;
    logic [13:0] req_beats = '0;
    logic        write_valid = 1'b0, write_ready;
    logic [31:0] write_data = '0;
    logic [3:0]  write_strb = '0;
    logic        read_valid, read_ready = 1'b0;
    logic [31:0] read_data;
    logic        err_o;

    osd_mam_wb_burst_if_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) wb ();

    osd_mam_wb_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_ready(write_ready),
        .write_data(write_data), .write_strb(write_strb),
        .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
        .err_o(err_o), .wb(wb)
    );

    // ---- wrap instance (8-bit address) ----
    logic        b_req_valid = 1'b0, b_req_ready, b_req_rw = 1'b0, b_req_burst = 1'b0;
    logic [7:0]  b_req_addr = '0;
    logic [13:0] b_req_beats = '0;
    logic        b_write_valid = 1'b0, b_write_ready;
    logic [31:0] b_write_data = '0;
    logic [3:0]  b_write_strb = '0;
    logic        b_read_valid, b_read_ready = 1'b0;
    logic [31:0] b_read_data;
    logic        b_err_o;

    osd_mam_wb_burst_if_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) wb8 ();

    osd_mam_wb_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_FIFO_DEPTH(4)) dut8 (
        .clk_i(clk), .rst_i(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_rw(b_req_rw),
        .req_addr(b_req_addr), .req_burst(b_req_burst), .req_beats(b_req_beats),
        .write_valid(b_write_valid), .write_ready(b_write_ready),
        .write_data(b_write_data), .write_strb(b_write_strb),
        .read_valid(b_read_valid), .read_ready(b_read_ready), .read_data(b_read_data),
        .err_o(b_err_o), .wb(wb8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // observations from the last do_xfer
    logic [31:0] obs_addr[$], obs_dat[$], exp_rd[$], got_rd[$], wq[$];
    logic [2:0]  obs_cti[$];
    logic [3:0]  obs_sel[$];
    logic        obs_we[$];
    logic [1:0]  obs_bte[$];
    int          wr_pulses, wait_cyc, cyc_drop, first_stall, done_cyc;
    bit          timeout;
    logic        err_at_accept;

    // Issue one request and act as the slave until the block is idle again.
    task automatic do_xfer(input bit rw, input logic [31:0] a, input bit burst,
                           input logic [13:0] beats, input logic [3:0] strb,
                           input int err_beat, input int rr_hold, input bit wv_alt,
                           input int ack_pct, input int rr_pct);
        int nbeat = 0;
        int cyc_n = 0;
        int n_exp;
        bit done = 1'b0;
        bit hit;
        n_exp = (burst && beats != 14'd0) ? int'(beats) : 1;
        obs_addr.delete(); obs_dat.delete(); exp_rd.delete(); got_rd.delete();
        obs_cti.delete(); obs_sel.delete(); obs_we.delete(); obs_bte.delete();
        wr_pulses = 0; wait_cyc = 0; cyc_drop = 0; first_stall = -1; timeout = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_burst = burst;
        req_beats = beats; write_strb = strb;
        @(posedge clk); #1;
        req_valid = 1'b0;
        err_at_accept = err_o;
        while (!done && cyc_n < 2000) begin
            write_valid = wv_alt ? (cyc_n % 2 == 0) : 1'b1;
            write_data  = (nbeat < wq.size()) ? wq[nbeat] : 32'h0;
            read_ready  = (cyc_n >= rr_hold) && ($urandom_range(0, 99) < rr_pct);
            #1;
            hit = wb.stb_o && ($urandom_range(0, 99) < ack_pct);
            wb.err_i = hit && (nbeat == err_beat);
            wb.ack_i = hit && (nbeat != err_beat);
            wb.dat_i = $urandom;
            @(negedge clk);
            if (wb.stb_o && (wb.ack_i || wb.err_i)) begin
                obs_addr.push_back(wb.addr_o); obs_cti.push_back(wb.cti_o);
                obs_sel.push_back(wb.sel_o);   obs_we.push_back(wb.we_o);
                obs_bte.push_back(wb.bte_o);   obs_dat.push_back(wb.dat_o);
                if (!rw) exp_rd.push_back(wb.dat_i);
                nbeat++;
            end
            if (write_ready) wr_pulses++;
            if (wb.cyc_o && !wb.stb_o) begin
                wait_cyc++;
                if (first_stall < 0) first_stall = nbeat;
            end
            if (!wb.cyc_o && nbeat < n_exp) cyc_drop++;
            if (read_valid && read_ready) got_rd.push_back(read_data);
            if (req_ready) done = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc_n++;
            end
        end
        done_cyc = cyc_n;
        timeout  = !done;
        wb.ack_i = 1'b0; wb.err_i = 1'b0;
        write_valid = 1'b0; read_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; #1;
        n_checks++; if (wb.cyc_o !== 1'b0) $display("FAIL rst_cyc: got %b exp 0", wb.cyc_o); else n_pass++;
        n_checks++; if (wb.stb_o !== 1'b0) $display("FAIL rst_stb: got %b exp 0", wb.stb_o); else n_pass++;
        n_checks++; if (wb.addr_o !== 32'h0) $display("FAIL rst_addr: got %h exp 0", wb.addr_o); else n_pass++;
        n_checks++; if (wb.we_o !== 1'b0) $display("FAIL rst_we: got %b exp 0", wb.we_o); else n_pass++;
        n_checks++; if (wb.sel_o !== 4'h0) $display("FAIL rst_sel: got %h exp 0", wb.sel_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b exp 0", err_o); else n_pass++;
        n_checks++; if (read_valid !== 1'b0) $display("FAIL rst_rvalid: got %b exp 0", read_valid); else n_pass++;
        n_checks++; if (write_ready !== 1'b0) $display("FAIL rst_wready: got %b exp 0", write_ready); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b exp 1", req_ready); else n_pass++;
        n_checks++; if (wb.cti_o !== 3'b000) $display("FAIL rst_cti: got %b exp 000", wb.cti_o); else n_pass++;
    endtask

    task automatic test_single_write();
        wq.delete(); wq.push_back(32'hDEADBEEF);
        // non-zero beat count without burst must still be one beat
        do_xfer(1'b1, 32'h100, 1'b0, 14'd5, 4'b0011, -1, 0, 1'b0, 100, 100);
        n_checks++; if (timeout) $display("FAIL sw_timeout: no return to idle"); else n_pass++;
        n_checks++; if (obs_addr.size() != 1) $display("FAIL sw_beats: got %0d exp 1", obs_addr.size()); else n_pass++;
        n_checks++; if (obs_addr[0] !== 32'h100) $display("FAIL sw_addr: got %h exp 100", obs_addr[0]); else n_pass++;
        n_checks++; if (obs_cti[0] !== 3'b000) $display("FAIL sw_cti: got %b exp 000", obs_cti[0]); else n_pass++;
        n_checks++; if (obs_sel[0] !== 4'b0011) $display("FAIL sw_sel: got %b exp 0011", obs_sel[0]); else n_pass++;
        n_checks++; if (obs_dat[0] !== 32'hDEADBEEF) $display("FAIL sw_dat: got %h exp deadbeef", obs_dat[0]); else n_pass++;
        n_checks++; if (obs_we[0] !== 1'b1) $display("FAIL sw_we: got %b exp 1", obs_we[0]); else n_pass++;
        n_checks++; if (wr_pulses != 1) $display("FAIL sw_wready: got %0d pulses exp 1", wr_pulses); else n_pass++;
        n_checks++; if (done_cyc != 1) $display("FAIL sw_latency: got %0d cycles exp 1", done_cyc); else n_pass++;
    endtask

    task automatic test_burst_write();
        logic [31:0] ea;
        logic [2:0]  ec;
        wq.delete();
        for (int k = 0; k < 4; k++) wq.push_back($urandom);
        do_xfer(1'b1, 32'h200, 1'b1, 14'd4, 4'b0001, -1, 0, 1'b1, 100, 100);
        n_checks++; if (timeout) $display("FAIL bw_timeout: no return to idle"); else n_pass++;
        n_checks++; if (obs_addr.size() != 4) $display("FAIL bw_beats: got %0d exp 4", obs_addr.size()); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            ea = 32'h200 + 32'(4 * k);
            ec = (k == 3) ? 3'b111 : 3'b010;
            n_checks++; if (obs_addr[k] !== ea) $display("FAIL bw_addr[%0d]: got %h exp %h", k, obs_addr[k], ea); else n_pass++;
            n_checks++; if (obs_cti[k] !== ec) $display("FAIL bw_cti[%0d]: got %b exp %b", k, obs_cti[k], ec); else n_pass++;
            n_checks++; if (obs_sel[k] !== 4'hF) $display("FAIL bw_sel[%0d]: got %h exp f", k, obs_sel[k]); else n_pass++;
            n_checks++; if (obs_dat[k] !== wq[k]) $display("FAIL bw_dat[%0d]: got %h exp %h", k, obs_dat[k], wq[k]); else n_pass++;
        end
        n_checks++; if (cyc_drop != 0) $display("FAIL bw_cyc_held: cyc low %0d cycles exp 0", cyc_drop); else n_pass++;
        n_checks++; if (wait_cyc == 0) $display("FAIL bw_wait: got 0 stall cycles exp >0"); else n_pass++;
        n_checks++; if (wr_pulses != 4) $display("FAIL bw_wready: got %0d exp 4", wr_pulses); else n_pass++;
    endtask

    task automatic test_burst_read();
        logic [31:0] ea;
        wq.delete();
        do_xfer(1'b0, 32'h400, 1'b1, 14'd8, 4'h0, -1, 10, 1'b0, 100, 70);
        n_checks++; if (timeout) $display("FAIL br_timeout: no return to idle"); else n_pass++;
        n_checks++; if (first_stall != 4) $display("FAIL br_stall_at: got %0d exp 4", first_stall); else n_pass++;
        n_checks++; if (cyc_drop != 0) $display("FAIL br_cyc_held: cyc low %0d cycles exp 0", cyc_drop); else n_pass++;
        n_checks++; if (obs_addr.size() != 8) $display("FAIL br_beats: got %0d exp 8", obs_addr.size()); else n_pass++;
        n_checks++; if (got_rd.size() != 8) $display("FAIL br_words: got %0d exp 8", got_rd.size()); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            ea = 32'h400 + 32'(4 * k);
            n_checks++; if (obs_addr[k] !== ea) $display("FAIL br_addr[%0d]: got %h exp %h", k, obs_addr[k], ea); else n_pass++;
            n_checks++; if (got_rd[k] !== exp_rd[k]) $display("FAIL br_data[%0d]: got %h exp %h", k, got_rd[k], exp_rd[k]); else n_pass++;
        end
        n_checks++; if (obs_we[0] !== 1'b0 || obs_sel[0] !== 4'hF) $display("FAIL br_we_sel: got we=%b sel=%h exp 0/f", obs_we[0], obs_sel[0]); else n_pass++;
    endtask

    task automatic test_read_throughput();
        wq.delete();
        do_xfer(1'b0, 32'h800, 1'b1, 14'd6, 4'h0, -1, 0, 1'b0, 100, 100);
        n_checks++; if (done_cyc != 7) $display("FAIL tp_cycles: got %0d exp 7", done_cyc); else n_pass++;
        n_checks++; if (wait_cyc != 0) $display("FAIL tp_wait: got %0d exp 0", wait_cyc); else n_pass++;
        n_checks++; if (got_rd.size() != 6) $display("FAIL tp_words: got %0d exp 6", got_rd.size()); else n_pass++;
    endtask

    task automatic test_read_error();
        wq.delete();
        do_xfer(1'b0, 32'h600, 1'b1, 14'd3, 4'h0, 1, 0, 1'b0, 100, 60);
        n_checks++; if (timeout) $display("FAIL re_timeout: no return to idle"); else n_pass++;
        n_checks++; if (got_rd.size() != 3) $display("FAIL re_words: got %0d exp 3", got_rd.size()); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (got_rd[k] !== exp_rd[k]) $display("FAIL re_data[%0d]: got %h exp %h", k, got_rd[k], exp_rd[k]); else n_pass++;
        end
        n_checks++; if (err_o !== 1'b1) $display("FAIL re_err_set: got %b exp 1", err_o); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (err_o !== 1'b1) $display("FAIL re_err_sticky: got %b exp 1", err_o); else n_pass++;
        wq.delete(); wq.push_back($urandom);
        do_xfer(1'b1, 32'h700, 1'b0, 14'd0, 4'hF, -1, 0, 1'b0, 100, 100);
        n_checks++; if (err_at_accept !== 1'b0) $display("FAIL re_err_clear: got %b exp 0", err_at_accept); else n_pass++;
    endtask

    task automatic test_burst_one();
        wq.delete(); wq.push_back($urandom);
        do_xfer(1'b1, 32'h900, 1'b1, 14'd0, 4'b0101, -1, 0, 1'b0, 100, 100);
        n_checks++; if (obs_addr.size() != 1) $display("FAIL b1_beats: got %0d exp 1", obs_addr.size()); else n_pass++;
        n_checks++; if (obs_cti[0] !== 3'b111) $display("FAIL b1_cti: got %b exp 111", obs_cti[0]); else n_pass++;
        n_checks++; if (obs_sel[0] !== 4'hF) $display("FAIL b1_sel: got %h exp f", obs_sel[0]); else n_pass++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            bit          rw, burst, wv;
            logic [31:0] a, ea;
            logic [13:0] beats;
            logic [3:0]  strb, es;
            logic [2:0]  ec;
            int          n, eb;
            rw    = 1'($urandom_range(0, 1));
            burst = 1'($urandom_range(0, 1));
            wv    = 1'($urandom_range(0, 1));
            a     = $urandom & 32'hFFFF_FFFC;
            beats = 14'($urandom_range(0, 7));
            strb  = 4'($urandom_range(0, 15));
            n     = (burst && beats != 14'd0) ? int'(beats) : 1;
            eb    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back($urandom);
            do_xfer(rw, a, burst, beats, strb, eb, int'($urandom_range(0, 6)), wv, 60, 60);
            n_checks++; if (timeout || obs_addr.size() != n) $display("FAIL rnd%0d_beats: got %0d exp %0d", t, obs_addr.size(), n); else n_pass++;
            for (int k = 0; k < n; k++) begin
                ea = a + 32'(4 * k);
                ec = !burst ? 3'b000 : (k == n - 1) ? 3'b111 : 3'b010;
                es = (rw && !burst) ? strb : 4'hF;
                n_checks++; if (obs_addr[k] !== ea) $display("FAIL rnd%0d_addr[%0d]: got %h exp %h", t, k, obs_addr[k], ea); else n_pass++;
                n_checks++; if (obs_cti[k] !== ec || obs_bte[k] !== 2'b00) $display("FAIL rnd%0d_cti[%0d]: got %b/%b exp %b/00", t, k, obs_cti[k], obs_bte[k], ec); else n_pass++;
                n_checks++; if (obs_sel[k] !== es || obs_we[k] !== rw) $display("FAIL rnd%0d_sel[%0d]: got %h/%b exp %h/%b", t, k, obs_sel[k], obs_we[k], es, rw); else n_pass++;
                if (rw) begin
                    n_checks++; if (obs_dat[k] !== wq[k]) $display("FAIL rnd%0d_wdat[%0d]: got %h exp %h", t, k, obs_dat[k], wq[k]); else n_pass++;
                end else begin
                    n_checks++; if (got_rd[k] !== exp_rd[k]) $display("FAIL rnd%0d_rdat[%0d]: got %h exp %h", t, k, got_rd[k], exp_rd[k]); else n_pass++;
                end
            end
            n_checks++; if (err_o !== (eb >= 0)) $display("FAIL rnd%0d_err: got %b exp %b", t, err_o, (eb >= 0)); else n_pass++;
            n_checks++; if (err_at_accept !== 1'b0) $display("FAIL rnd%0d_err_clear: got %b exp 0", t, err_at_accept); else n_pass++;
            n_checks++; if (wr_pulses != (rw ? n : 0)) $display("FAIL rnd%0d_wready: got %0d exp %0d", t, wr_pulses, rw ? n : 0); else n_pass++;
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0]  seen[$];
        logic [31:0] pushed[$], popped[$];
        int cyc = 0;
        @(posedge clk); #1;
        b_req_valid = 1'b1; b_req_rw = 1'b0; b_req_addr = 8'hFC;
        b_req_burst = 1'b1; b_req_beats = 14'd2; b_read_ready = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0; wb8.ack_i = 1'b1; wb8.dat_i = $urandom;
        while (!b_req_ready && cyc < 20) begin
            @(negedge clk);
            if (wb8.stb_o && wb8.ack_i) begin
                seen.push_back(wb8.addr_o);
                pushed.push_back(wb8.dat_i);
            end
            if (b_read_valid && b_read_ready) popped.push_back(b_read_data);
            @(posedge clk); #1;
            wb8.dat_i = $urandom;
            cyc++;
        end
        wb8.ack_i = 1'b0; b_read_ready = 1'b0;
        n_checks++; if (cyc >= 20) $display("FAIL wrap_timeout: no return to idle"); else n_pass++;
        n_checks++; if (seen.size() != 2) $display("FAIL wrap_beats: got %0d exp 2", seen.size()); else n_pass++;
        n_checks++; if (seen[0] !== 8'hFC) $display("FAIL wrap_addr0: got %h exp fc", seen[0]); else n_pass++;
        n_checks++; if (seen[1] !== 8'h00) $display("FAIL wrap_addr1: got %h exp 00", seen[1]); else n_pass++;
        n_checks++; if (popped.size() != 2 || popped[1] !== pushed[1]) $display("FAIL wrap_data: got %0d words exp 2", popped.size()); else n_pass++;
        n_checks++; if (b_err_o !== 1'b0 || b_write_ready !== 1'b0) $display("FAIL wrap_flags: got err=%b wr=%b exp 0/0", b_err_o, b_write_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int nb = 0;
        int cyc = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h500;
        req_burst = 1'b1; req_beats = 14'd4; read_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; wb.ack_i = 1'b1; wb.dat_i = $urandom;
        while (nb < 2 && cyc < 20) begin
            @(negedge clk);
            if (wb.stb_o && wb.ack_i) nb++;
            @(posedge clk); #1;
            wb.dat_i = $urandom;
            cyc++;
        end
        n_checks++; if (nb != 2 || read_valid !== 1'b1 || wb.cyc_o !== 1'b1) $display("FAIL rm_setup: got beats=%0d rv=%b cyc=%b exp 2/1/1", nb, read_valid, wb.cyc_o); else n_pass++;
        rst = 1'b1; #1;
        n_checks++; if (wb.cyc_o !== 1'b0) $display("FAIL rm_cyc: got %b exp 0", wb.cyc_o); else n_pass++;
        n_checks++; if (wb.stb_o !== 1'b0) $display("FAIL rm_stb: got %b exp 0", wb.stb_o); else n_pass++;
        n_checks++; if (read_valid !== 1'b0) $display("FAIL rm_rvalid: got %b exp 0", read_valid); else n_pass++;
        n_checks++; if (wb.addr_o !== 32'h0) $display("FAIL rm_addr: got %h exp 0", wb.addr_o); else n_pass++;
        wb.ack_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rm_req_ready: got %b exp 1", req_ready); else n_pass++;
        n_checks++; if (read_valid !== 1'b0 || wb.cyc_o !== 1'b0) $display("FAIL rm_after: got rv=%b cyc=%b exp 0/0", read_valid, wb.cyc_o); else n_pass++;
    endtask

    initial begin
        wb.ack_i  = 1'b0; wb.err_i  = 1'b0; wb.dat_i  = '0;
        wb8.ack_i = 1'b0; wb8.err_i = 1'b0; wb8.dat_i = '0;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_single_write();
        test_burst_write();
        test_burst_read();
        test_read_throughput();
        test_read_error();
        test_burst_one();
        test_random();
        test_addr_wrap();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
